vmicro16_timer_multi_apb: RTL

//   Multi-channel APB timer. Each channel has its own prescaler, reload

---
 rtl/vmicro16_timer_multi_apb.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vmicro16_timer_multi_apb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vmicro16_timer_multi_apb
// Brief    : Multi-channel APB timer: per-channel prescaler, reload counter,
//            one-shot/periodic mode, sticky pending flag and expiry pulse.
// Revision : 1.0 - initial release
// ============================================================================
module vmicro16_timer_multi_apb #(
  parameter DATA_WIDTH = 16,
  parameter CHANNELS   = 4,
  parameter NAME       = "TIMR"
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(CHANNELS)+1:0]   S_PADDR,
  input  logic                          S_PWRITE,
  input  logic                          S_PSELx,
  input  logic                          S_PENABLE,
  input  logic [DATA_WIDTH-1:0]         S_PWDATA,
  output logic [DATA_WIDTH-1:0]         S_PRDATA,
  output logic                          S_PREADY,
  output logic [CHANNELS-1:0]           out,
  output logic [CHANNELS-1:0]           irq_vec,
  output logic                          irq
);

  localparam int                    c_ch_w     = $clog2(CHANNELS);
  localparam logic [1:0]            c_reg_load = 2'd0;
  localparam logic [1:0]            c_reg_ctrl = 2'd1;
  localparam logic [1:0]            c_reg_pres = 2'd2;
  localparam logic [1:0]            c_reg_stat = 2'd3;
  localparam logic [DATA_WIDTH-1:0] c_one      = DATA_WIDTH'(1);

  if ((CHANNELS < 2) || (CHANNELS > 16) || ((CHANNELS & (CHANNELS - 1)) != 0)) begin : g_bad_channels
    $error("%s: CHANNELS must be a power of two in 2..16", NAME);
  end

  logic                  w_en;
  logic [c_ch_w-1:0]     w_ch;
  logic [1:0]            w_reg;
  logic [CHANNELS-1:0]   w_wr_load;
  logic [CHANNELS-1:0]   w_wr_ctrl;
  logic [CHANNELS-1:0]   w_wr_pres;
  logic [CHANNELS-1:0]   w_wr_stat;
  logic [CHANNELS-1:0]   w_tick;
  logic [CHANNELS-1:0]   w_expire;

  logic [DATA_WIDTH-1:0] r_load     [CHANNELS];
  logic [DATA_WIDTH-1:0] r_count    [CHANNELS];
  logic [DATA_WIDTH-1:0] r_pres     [CHANNELS];
  logic [DATA_WIDTH-1:0] r_pres_cnt [CHANNELS];
  logic [CHANNELS-1:0]   r_start;
  logic [CHANNELS-1:0]   r_oneshot;
  logic [CHANNELS-1:0]   r_inten;
  logic [CHANNELS-1:0]   r_pending;
  logic [CHANNELS-1:0]   r_out;

  assign w_en     = S_PSELx & S_PENABLE;
  assign w_ch     = S_PADDR[c_ch_w+1:2];
  assign w_reg    = S_PADDR[1:0];
  assign S_PREADY = w_en;
  assign out      = r_out;
  assign irq_vec  = r_pending & r_inten;
  assign irq      = |irq_vec;

  // A LOAD/CTRL write owns the channel for that cycle, so its tick is dropped.
  always_comb begin
    w_wr_load = '0;
    w_wr_ctrl = '0;
    w_wr_pres = '0;
    w_wr_stat = '0;
    w_tick    = '0;
    w_expire  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_en && S_PWRITE && (w_ch == c_ch_w'(i))) begin
        w_wr_load[i] = (w_reg == c_reg_load);
        w_wr_ctrl[i] = (w_reg == c_reg_ctrl);
        w_wr_pres[i] = (w_reg == c_reg_pres);
        w_wr_stat[i] = (w_reg == c_reg_stat);
      end
      w_tick[i]   = r_start[i] && (r_pres_cnt[i] == '0) && !w_wr_load[i] && !w_wr_ctrl[i];
      w_expire[i] = w_tick[i] && (r_count[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_load[i]     <= '0;
        r_count[i]    <= '0;
        r_pres[i]     <= '0;
        r_pres_cnt[i] <= '0;
      end
      r_start   <= '0;
      r_oneshot <= '0;
      r_inten   <= '0;
      r_pending <= '0;
      r_out     <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_out[i] <= w_expire[i];

        if (!r_start[i] || (r_pres_cnt[i] == '0)) begin
          r_pres_cnt[i] <= r_pres[i];
        end else begin
          r_pres_cnt[i] <= r_pres_cnt[i] - c_one;
        end

        if (w_wr_load[i]) begin
          r_load[i]  <= S_PWDATA;
          r_count[i] <= S_PWDATA;
        end else if (w_tick[i]) begin
          if (r_count[i] != '0) begin
            r_count[i] <= r_count[i] - c_one;
          end else if (!r_oneshot[i]) begin
            r_count[i] <= r_load[i];
          end
        end

        if (w_wr_ctrl[i]) begin
          r_start[i]   <= S_PWDATA[0];
          r_oneshot[i] <= S_PWDATA[1];
          r_inten[i]   <= S_PWDATA[2];
        end else if (w_expire[i] && r_oneshot[i]) begin
          r_start[i] <= 1'b0;
        end

        if (w_wr_pres[i]) begin
          r_pres[i] <= S_PWDATA;
        end

        // A new expiry beats a same-cycle clear so no interrupt is lost.
        if (w_expire[i] && r_inten[i]) begin
          r_pending[i] <= 1'b1;
        end else if (w_wr_stat[i] && S_PWDATA[0]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    S_PRDATA = '0;
    if (w_en) begin
      case (w_reg)
        c_reg_load: S_PRDATA = r_count[w_ch];
        c_reg_ctrl: S_PRDATA = DATA_WIDTH'({r_inten[w_ch], r_oneshot[w_ch], r_start[w_ch]});
        c_reg_pres: S_PRDATA = r_pres[w_ch];
        default:    S_PRDATA = DATA_WIDTH'(r_pending[w_ch]);
      endcase
    end
  end

endmodule
`default_nettype wire
